// File: rtl/bsg_rr_one_hot_sel_pkg.sv
// bsg_rr_one_hot_sel_pkg
//   Shared types and helpers for the round-robin one-hot select arbiter.
//   rr_state_e    : arbiter FSM state (idle / holding a grant)
//   onehot_to_id  : binary index of the set bit of a one-hot vector (up to 64 bits);
//                   used by the arbiter's consistency checks.
package bsg_rr_one_hot_sel_pkg;

  typedef enum logic [0:0] {
    eIdle = 1'b0,
    eHold = 1'b1
  } rr_state_e;

  function automatic logic [5:0] onehot_to_id(input logic [63:0] oh);
    logic [5:0] id;
    id = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (oh[i]) id = 6'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/bsg_rr_rotate_pri_enc.sv
// bsg_rr_rotate_pri_enc
//   Combinational rotating-priority encoder. Searches req upward from index
//   start, wrapping past els_p-1 to 0, and reports the first set bit.
//   Ports:
//     req    in   els_p      request vector
//     start  in   lg_els_lp  first index searched (must be < els_p)
//     grant  out  els_p      one-hot winner (zero when no request)
//     id     out  lg_els_lp  binary index of the winner (zero when no request)
//     any_v  out  1          at least one request present
module bsg_rr_rotate_pri_enc #(
  parameter  int unsigned els_p     = 1,
  localparam int unsigned lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic [els_p-1:0]     req,
  input  logic [lg_els_lp-1:0] start,
  output logic [els_p-1:0]     grant,
  output logic [lg_els_lp-1:0] id,
  output logic                 any_v
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any_v = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < els_p; i++) begin
      idx = 32'(start) + i;
      if (idx >= els_p) idx = idx - els_p;
      if (!any_v && req[idx]) begin
        any_v      = 1'b1;
        grant[idx] = 1'b1;
        id         = lg_els_lp'(idx);
      end
    end
  end

endmodule

// File: rtl/bsg_rr_one_hot_sel.sv
// bsg_rr_one_hot_sel
//   Round-robin arbiter feeding a one-hot data mux. Registers a one-hot grant
//   among valid-only requesters and holds it until the consumer accepts.
//   Optional build macro: BSG_RR_ONE_HOT_SEL_BACK_TO_BACK_EN -- re-arbitrate
//   on accept so a new grant can be held every cycle (otherwise one idle
//   cycle between grants).
//   Ports:
//     clk_i          in   1          clock, rising edge
//     reset_i        in   1          synchronous active-high reset
//     v_i            in   els_p      per-source request valid
//     yumi_o         out  els_p      pop to the granted source on accept
//     sel_one_hot_o  out  els_p      registered one-hot grant (mux select)
//     sel_id_o       out  lg_els_lp  binary index of the granted source
//     v_o            out  1          grant valid to consumer
//     yumi_i         in   1          consumer accepts granted item
module bsg_rr_one_hot_sel
  import bsg_rr_one_hot_sel_pkg::*;
#(
  parameter  int unsigned els_p     = 1,
  localparam int unsigned lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [els_p-1:0]     v_i,
  output logic [els_p-1:0]     yumi_o,
  output logic [els_p-1:0]     sel_one_hot_o,
  output logic [lg_els_lp-1:0] sel_id_o,
  output logic                 v_o,
  input  logic                 yumi_i
);

  rr_state_e            state_r, state_n;
  logic [els_p-1:0]     sel_oh_r, sel_oh_n;
  logic [lg_els_lp-1:0] sel_id_r, sel_id_n;
  logic [lg_els_lp-1:0] last_r, last_n;

  logic [els_p-1:0]     enc_req, enc_grant;
  logic [lg_els_lp-1:0] enc_start, enc_id, ptr;
  logic                 enc_any;

  localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_p - 1);

  assign v_o           = (state_r == eHold);
  assign sel_one_hot_o = sel_oh_r;
  assign sel_id_o      = sel_id_r;
  assign yumi_o        = sel_oh_r & {els_p{yumi_i & v_o}};

  // In HOLD the encoder sees the pointer as it will be after this accept
  // (the served id) and excludes the source being popped this cycle.
  assign ptr       = (state_r == eHold) ? sel_id_r : last_r;
  assign enc_start = (ptr == last_idx_lp) ? '0 : ptr + 1'b1;
  assign enc_req   = (state_r == eHold) ? (v_i & ~yumi_o) : v_i;

  bsg_rr_rotate_pri_enc #(.els_p(els_p)) enc (
    .req   (enc_req),
    .start (enc_start),
    .grant (enc_grant),
    .id    (enc_id),
    .any_v (enc_any)
  );

  always_comb begin
    state_n  = state_r;
    sel_oh_n = sel_oh_r;
    sel_id_n = sel_id_r;
    last_n   = last_r;
    unique case (state_r)
      eIdle: begin
        if (enc_any) begin
          state_n  = eHold;
          sel_oh_n = enc_grant;
          sel_id_n = enc_id;
        end
      end
      eHold: begin
        if (yumi_i) begin
          last_n   = sel_id_r;
          state_n  = eIdle;
          sel_oh_n = '0;
          sel_id_n = '0;
`ifdef BSG_RR_ONE_HOT_SEL_BACK_TO_BACK_EN
          if (enc_any) begin
            state_n  = eHold;
            sel_oh_n = enc_grant;
            sel_id_n = enc_id;
          end
`endif
        end
      end
      default: state_n = eIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= eIdle;
      sel_oh_r <= '0;
      sel_id_r <= '0;
      last_r   <= last_idx_lp;
    end else begin
      state_r  <= state_n;
      sel_oh_r <= sel_oh_n;
      sel_id_r <= sel_id_n;
      last_r   <= last_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("bsg_rr_one_hot_sel: yumi_i asserted with v_o low");
      if (state_r == eHold) begin
        assert ((v_i & sel_oh_r) != '0)
          else $error("bsg_rr_one_hot_sel: granted source dropped v_i while held");
        assert (onehot_to_id(64'(sel_oh_r)) == 6'(sel_id_r))
          else $error("bsg_rr_one_hot_sel: sel_id_o inconsistent with sel_one_hot_o");
      end
    end
  end

endmodule

// File: tb/tb_bsg_rr_one_hot_sel.sv
module tb_bsg_rr_one_hot_sel;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] v_i;
  logic [3:0] yumi_o;
  logic [3:0] sel_one_hot_o;
  logic [1:0] sel_id_o;
  logic       v_o;
  logic       yumi_i;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  bsg_rr_one_hot_sel #(.els_p(4)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .v_i           (v_i),
    .yumi_o        (yumi_o),
    .sel_one_hot_o (sel_one_hot_o),
    .sel_id_o      (sel_id_o),
    .v_o           (v_o),
    .yumi_i        (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic logic [1:0] mux_out(input logic [3:0] sel);
    logic [1:0] data [4];
    logic [1:0] r;
    r = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      data[k] = 2'(k);
      if (sel[k]) r = r | data[k];
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g;
    reset_i = 1'b1;
    v_i     = '0;
    yumi_i  = 1'b0;
    step();
    step();
    chk("rst_v_o", 8'(v_o), 8'h0);
    chk("rst_sel", 8'(sel_one_hot_o), 8'h0);
    chk("rst_id", 8'(sel_id_o), 8'h0);
    chk("rst_yumi", 8'(yumi_o), 8'h0);
    reset_i = 1'b0;

    // no requests: nothing granted
    for (int unsigned c = 0; c < 10; c++) begin
      step();
      chk("idle_v_o", 8'(v_o), 8'h0);
      chk("idle_sel", 8'(sel_one_hot_o), 8'h0);
      chk("idle_yumi", 8'(yumi_o), 8'h0);
    end

    // all requesting: strict rotation 0,1,2,3,0
    v_i = 4'b1111;
    step();
    for (int unsigned k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      chk("rot_v_o", 8'(v_o), 8'h1);
      chk("rot_sel", 8'(sel_one_hot_o), 8'(exp_g));
      chk("rot_id", 8'(sel_id_o), 8'(k % 4));
      if (k == 4) v_i = 4'b0001;
      yumi_i = 1'b1;
      #1;
      chk("rot_yumi", 8'(yumi_o), 8'(exp_g));
      step();
      yumi_i = 1'b0;
`ifndef BSG_RR_ONE_HOT_SEL_BACK_TO_BACK_EN
      if (k == 4) v_i = '0;
      chk("rot_bubble_v_o", 8'(v_o), 8'h0);
      chk("rot_bubble_sel", 8'(sel_one_hot_o), 8'h0);
      if (k != 4) step();
`endif
    end
    v_i = '0;
    step();
    chk("rot_end_v_o", 8'(v_o), 8'h0);

    // held grant is stable regardless of other requests
    v_i = 4'b0100;
    step();
    for (int unsigned c = 0; c < 5; c++) begin
      chk("hold_v_o", 8'(v_o), 8'h1);
      chk("hold_sel", 8'(sel_one_hot_o), 8'h04);
      chk("hold_id", 8'(sel_id_o), 8'h2);
      step();
    end
    v_i = 4'b1111;
    for (int unsigned c = 0; c < 3; c++) begin
      step();
      chk("hold_all_sel", 8'(sel_one_hot_o), 8'h04);
      chk("hold_all_id", 8'(sel_id_o), 8'h2);
    end
    v_i = 4'b0100;
    yumi_i = 1'b1;
    #1;
    chk("hold_yumi", 8'(yumi_o), 8'h04);
    step();
    yumi_i = 1'b0;
    v_i = '0;
    chk("hold_done_v_o", 8'(v_o), 8'h0);

    // wrap: serve source 1, then only 0 and 1 request -> 0 wins
    v_i = 4'b0010;
    step();
    chk("wrap_first_sel", 8'(sel_one_hot_o), 8'h02);
    v_i = 4'b0011;
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
`ifndef BSG_RR_ONE_HOT_SEL_BACK_TO_BACK_EN
    chk("wrap_bubble_v_o", 8'(v_o), 8'h0);
    step();
`endif
    chk("wrap_v_o", 8'(v_o), 8'h1);
    chk("wrap_sel", 8'(sel_one_hot_o), 8'h01);
    chk("wrap_id", 8'(sel_id_o), 8'h0);
    v_i = 4'b0001;
    yumi_i = 1'b1;
    #1;
    chk("wrap_yumi", 8'(yumi_o), 8'h01);
    step();
    yumi_i = 1'b0;
    v_i = '0;
    chk("wrap_done_v_o", 8'(v_o), 8'h0);

    // reset during HOLD with yumi_i high
    v_i = 4'b1111;
    step();
    chk("rsthold_sel", 8'(sel_one_hot_o), 8'h02);
    reset_i = 1'b1;
    yumi_i = 1'b1;
    step();
    chk("rsthold_v_o", 8'(v_o), 8'h0);
    chk("rsthold_yumi", 8'(yumi_o), 8'h0);
    chk("rsthold_sel0", 8'(sel_one_hot_o), 8'h0);
    yumi_i = 1'b0;
    reset_i = 1'b0;
    step();
    chk("rsthold_next_sel", 8'(sel_one_hot_o), 8'h01);
    chk("rsthold_next_id", 8'(sel_id_o), 8'h0);
    v_i = 4'b0001;
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    v_i = '0;
    chk("rsthold_done_v_o", 8'(v_o), 8'h0);

    // one-hot data mux with data[k]=k tracks sel_id_o
    v_i = 4'b1010;
    step();
    chk("mux1_sel", 8'(sel_one_hot_o), 8'h02);
    chk("mux1_id", 8'(sel_id_o), 8'h1);
    chk("mux1_out", 8'(mux_out(sel_one_hot_o)), 8'h1);
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
`ifndef BSG_RR_ONE_HOT_SEL_BACK_TO_BACK_EN
    step();
`endif
    chk("mux2_sel", 8'(sel_one_hot_o), 8'h08);
    chk("mux2_id", 8'(sel_id_o), 8'h3);
    chk("mux2_out", 8'(mux_out(sel_one_hot_o)), 8'h3);
    v_i = 4'b1000;
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    v_i = '0;
    chk("mux_done_v_o", 8'(v_o), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
